// File: rtl/collide_sweep_ctrl.sv
// Sweeps an NX x NY lattice through one shared collide datapath: read node, settle, write back.
// Latency: RD_LAT+3 cycles per node with wr_ready high; done pulses one cycle after the final write.
// Backpressure: wr_en, wr_addr and wr_data hold until wr_ready; no new read is issued while stalled.
module collide_sweep_ctrl #(
    parameter int NX     = 32,
    parameter int NY     = 32,
    parameter int AW     = 10,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   num_steps,
    output logic          busy,
    output logic          done,
    output logic [15:0]   step_cnt,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [242:0]  rd_data,
    input  logic          rd_barrier,
    output logic [242:0]  col_in,
    input  logic [242:0]  col_out,
    output logic          wr_en,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [242:0]  wr_data
);

    localparam int NODES = NX * NY;
    localparam int WW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        EVAL,
        WR,
        FIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] node_idx;
    logic [15:0]   steps_lat;
    logic [WW-1:0] wait_cnt;
    logic          barrier;
    logic          accept;
    logic          last_node;
    logic          wait_last;
    logic [15:0]   step_inc;

    assign accept    = wr_en & wr_ready;
    assign last_node = (node_idx == AW'(NODES - 1));
    assign wait_last = (wait_cnt == WW'(RD_LAT - 1));
    assign step_inc  = step_cnt + 16'd1;

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign rd_en   = (state == RD);
    assign wr_en   = (state == WR);
    assign rd_addr = node_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_steps == 16'd0) ? FIN : RD;
                end
            end
            RD:   state_nxt = WAIT;
            WAIT: begin
                if (wait_last) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: state_nxt = WR;
            WR: begin
                if (accept) begin
                    state_nxt = (last_node && (step_inc == steps_lat)) ? FIN : RD;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_idx  <= '0;
            step_cnt  <= '0;
            steps_lat <= '0;
            wait_cnt  <= '0;
            barrier   <= 1'b0;
            col_in    <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        node_idx  <= '0;
                        step_cnt  <= '0;
                        steps_lat <= num_steps;
                    end
                end
                RD: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    // col_in only moves here, so collide sees stable inputs through EVAL and WR
                    if (wait_last) begin
                        col_in  <= rd_data;
                        barrier <= rd_barrier;
                    end
                end
                EVAL: begin
                    wr_data <= barrier ? col_in : col_out;
                    wr_addr <= node_idx;
                end
                WR: begin
                    if (accept) begin
                        if (last_node) begin
                            node_idx <= '0;
                            step_cnt <= step_inc;
                        end else begin
                            node_idx <= node_idx + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
